// File: rtl/rpn_key_sequencer_if.sv
// Key-token and calculator-command handshakes of the RPN key sequencer.
// The master modport is the sequencer's view; the slave modport is the
// environment (key source plus calculator).
interface rpn_key_sequencer_if #(
    parameter int unsigned W = 16
) ();
    logic         key_valid;
    logic [4:0]   key_code;
    logic         key_ready;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_push;
    logic [W-1:0] cmd_d;
    logic [1:0]   cmd_op;

    modport master (
        input  key_valid, key_code, cmd_ready,
        output key_ready, cmd_valid, cmd_push, cmd_d, cmd_op
    );

    modport slave (
        output key_valid, key_code, cmd_ready,
        input  key_ready, cmd_valid, cmd_push, cmd_d, cmd_op
    );
endinterface

// File: rtl/rpn_key_sequencer.sv
// Turns calculator key tokens into push/operator commands, accumulating
// decimal digit entry and mirroring the calculator's stack depth so that
// commands it would silently drop are suppressed and flagged on err.
module rpn_key_sequencer #(
    parameter int unsigned DEPTH_MAX = 1000,
    parameter int unsigned W         = 16
) (
    input  logic                 step,
    input  logic                 rst,
    rpn_key_sequencer_if.master  bus,
    output logic [W-1:0]         entry,
    output logic                 entry_active,
    output logic [9:0]           depth,
    output logic                 err
);

    localparam logic [9:0] DepthMax = 10'(DEPTH_MAX);

    localparam logic [4:0] KeyEnter = 5'd10;
    localparam logic [4:0] KeyNeg   = 5'd11;
    localparam logic [4:0] KeyAdd   = 5'd12;
    localparam logic [4:0] KeyMul   = 5'd13;
    localparam logic [4:0] KeyClear = 5'd14;

    localparam logic [1:0] OpNone = 2'd0;
    localparam logic [1:0] OpNeg  = 2'd1;

    typedef enum logic [1:0] {StIdle, StPush, StOp} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] entry_q, entry_d;
    logic         active_q, active_d;
    logic [9:0]   depth_q, depth_d;
    logic [1:0]   op_q, op_d;
    logic         op_ok;

    // State register with immediate reset.
    always_ff @(posedge step or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            entry_q  <= '0;
            active_q <= 1'b0;
            depth_q  <= '0;
            op_q     <= OpNone;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            active_q <= active_d;
            depth_q  <= depth_d;
            op_q     <= op_d;
        end
    end

    // Next-state and handshake outputs; commands are driven straight from state
    // so they stay stable until the calculator takes them.
    always_comb begin
        state_d       = state_q;
        entry_d       = entry_q;
        active_d      = active_q;
        depth_d       = depth_q;
        op_d          = op_q;
        bus.key_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_push  = 1'b0;
        bus.cmd_d     = '0;
        bus.cmd_op    = OpNone;
        err           = 1'b0;
        // NEG needs one operand, ADD/MUL need two.
        op_ok         = (op_q == OpNeg) ? (depth_q >= 10'd1) : (depth_q >= 10'd2);

        unique case (state_q)
            StIdle: begin
                bus.key_ready = 1'b1;
                if (bus.key_valid) begin
                    if (bus.key_code <= 5'd9) begin
                        entry_d  = entry_q * W'(10) + W'(bus.key_code);
                        active_d = 1'b1;
                    end else begin
                        case (bus.key_code)
                            KeyEnter: begin
                                if (active_q) begin
                                    op_d    = OpNone;
                                    state_d = StPush;
                                end
                            end
                            KeyNeg, KeyAdd, KeyMul: begin
                                op_d    = 2'(bus.key_code - 5'd10);
                                state_d = active_q ? StPush : StOp;
                            end
                            KeyClear: begin
                                entry_d  = '0;
                                active_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            StPush: begin
                // Rejection issues no command, so it does not wait on cmd_ready.
                if (depth_q == DepthMax) begin
                    err      = 1'b1;
                    entry_d  = '0;
                    active_d = 1'b0;
                    op_d     = OpNone;
                    state_d  = StIdle;
                end else begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_push  = 1'b1;
                    bus.cmd_d     = entry_q;
                    if (bus.cmd_ready) begin
                        depth_d  = depth_q + 10'd1;
                        entry_d  = '0;
                        active_d = 1'b0;
                        state_d  = (op_q != OpNone) ? StOp : StIdle;
                    end
                end
            end

            StOp: begin
                if (!op_ok) begin
                    err     = 1'b1;
                    op_d    = OpNone;
                    state_d = StIdle;
                end else begin
                    bus.cmd_valid = 1'b1;
                    bus.cmd_op    = op_q;
                    if (bus.cmd_ready) begin
                        if (op_q != OpNeg) begin
                            depth_d = depth_q - 10'd1;
                        end
                        op_d    = OpNone;
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign entry        = entry_q;
    assign entry_active = active_q;
    assign depth        = depth_q;

endmodule
